tone_mixer_dac: RTL

Parametrised multi-voice successor to the single-tone audio path. It combines NUM_CH square-wave voices, with per-voice divider, volume and stereo pan, into one block. Voices are mixed with saturation into left/right 16-bit samples, which are serialised directly onto the DAC pins (appsel/sysclk/bck/ws/data). Configuration is double-buffered through a commit handshake, so new settings take effect glitch-free at a frame boundary.

---
 rtl/tone_mixer_pkg.sv | 24 ++
 rtl/tone_voice.sv | 43 ++++
 rtl/tone_mixer_dac.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/tone_mixer_pkg.sv
// Shared constants, handshake state type and frame-length helper for the tone mixer DAC.
package tone_mixer_pkg;

  localparam int SAMPLE_W = 16;
  localparam int VOL_W    = 15;

  localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

  localparam int PAN_L = 0;
  localparam int PAN_R = 1;

  typedef enum logic [1:0] {
    HS_INIT,
    HS_READY,
    HS_PENDING
  } hs_state_t;

  // One frame holds 32 bit-clock periods (16 left + 16 right).
  function automatic int frame_len(input int bck_log2);
    return 32 << bck_log2;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// Single square-wave voice: divider counter, polarity toggle and signed sample.
module tone_voice
  import tone_mixer_pkg::*;
#(
  parameter int DIV_W = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                restart,
  input  logic [DIV_W-1:0]    div,
  input  logic [VOL_W-1:0]    vol,
  output logic [SAMPLE_W-1:0] sample
);

  logic [DIV_W-1:0] cnt;
  logic             pol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      pol <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
      pol <= 1'b0;
    end else if (div == '0) begin
      cnt <= '0;
    end else if (cnt >= div - DIV_W'(1)) begin
      cnt <= '0;
      pol <= ~pol;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // A zero divider mutes the voice regardless of its stored polarity.
  always_comb begin
    sample = '0;
    if (div != '0) begin
      sample = pol ? (SAMPLE_W'(0) - {1'b0, vol}) : {1'b0, vol};
    end
  end

endmodule

// File: rtl/tone_mixer_dac.sv
// Multi-voice square-wave mixer with double-buffered config and left-justified DAC serialiser.
// Optional sticky saturation indicator enabled by defining TONE_MIXER_CLIP_FLAG_EN.
module tone_mixer_dac
  import tone_mixer_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int DIV_W    = 20,
  parameter  int BCK_LOG2 = 4,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             pb_in_rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [VOL_W-1:0] cfg_vol,
  input  logic [1:0]       cfg_pan,
  input  logic             cfg_commit,
  output logic             audio_appsel,
  output logic             audio_sysclk,
  output logic             audio_bck,
  output logic             audio_ws,
  output logic             audio_data
`ifdef TONE_MIXER_CLIP_FLAG_EN
  ,
  output logic             clip_flag
`endif
);

  localparam int CNT_W = BCK_LOG2 + 5;
  localparam int FRAME = frame_len(BCK_LOG2);
  localparam int SUM_W = SAMPLE_W + $clog2(NUM_CH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

  logic [CNT_W-1:0]    cnt;
  logic                boundary;
  logic                bck_fall;
  logic                appsel_q;
  hs_state_t           hs_q, hs_d;
  logic                apply;
  logic                wr_en;

  logic [DIV_W-1:0]    sh_div  [NUM_CH];
  logic [VOL_W-1:0]    sh_vol  [NUM_CH];
  logic [1:0]          sh_pan  [NUM_CH];
  logic [DIV_W-1:0]    act_div [NUM_CH];
  logic [VOL_W-1:0]    act_vol [NUM_CH];
  logic [1:0]          act_pan [NUM_CH];
  logic [NUM_CH-1:0]   restart;
  logic [SAMPLE_W-1:0] voice_sample [NUM_CH];

  logic [SUM_W-1:0]    sum_l, sum_r;
  logic                l_ovf, r_ovf;
  logic [SAMPLE_W-1:0] l_sat, r_sat;
  logic [31:0]         shreg;

  assign boundary = (cnt == CNT_LAST);
  assign bck_fall = &cnt[BCK_LOG2-1:0];

  always_ff @(posedge clk or negedge pb_in_rst) begin
    if (!pb_in_rst) begin
      cnt      <= '0;
      appsel_q <= 1'b0;
    end else begin
      cnt      <= cnt + CNT_W'(1);
      appsel_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge pb_in_rst) begin
    if (!pb_in_rst) hs_q <= HS_INIT;
    else            hs_q <= hs_d;
  end

  // Once a commit is accepted, the port stays closed until the next frame boundary copies the set.
  always_comb begin
    hs_d  = hs_q;
    apply = 1'b0;
    case (hs_q)
      HS_INIT:    hs_d = HS_READY;
      HS_READY:   if (cfg_commit) hs_d = HS_PENDING;
      HS_PENDING: begin
        if (boundary) begin
          hs_d  = HS_READY;
          apply = 1'b1;
        end
      end
      default:    hs_d = HS_INIT;
    endcase
  end

  assign cfg_ready = (hs_q == HS_READY);
  assign wr_en     = cfg_valid && cfg_ready;

  // Out-of-range channel numbers never match a slot, so such writes simply vanish.
  always_ff @(posedge clk or negedge pb_in_rst) begin
    if (!pb_in_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sh_div[i]  <= '0;
        sh_vol[i]  <= '0;
        sh_pan[i]  <= '0;
        act_div[i] <= '0;
        act_vol[i] <= '0;
        act_pan[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en && (int'(cfg_ch) == i)) begin
          sh_div[i] <= cfg_div;
          sh_vol[i] <= cfg_vol;
          sh_pan[i] <= cfg_pan;
        end
        if (apply) begin
          act_div[i] <= sh_div[i];
          act_vol[i] <= sh_vol[i];
          act_pan[i] <= sh_pan[i];
        end
      end
    end
  end

  always_comb begin
    restart = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      restart[i] = apply && (sh_div[i] != act_div[i]);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
    tone_voice #(
      .DIV_W (DIV_W)
    ) u_voice (
      .clk     (clk),
      .rst_n   (pb_in_rst),
      .restart (restart[g]),
      .div     (act_div[g]),
      .vol     (act_vol[g]),
      .sample  (voice_sample[g])
    );
  end

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (act_pan[i][PAN_L]) begin
        sum_l = sum_l + {{(SUM_W-SAMPLE_W){voice_sample[i][SAMPLE_W-1]}}, voice_sample[i]};
      end
      if (act_pan[i][PAN_R]) begin
        sum_r = sum_r + {{(SUM_W-SAMPLE_W){voice_sample[i][SAMPLE_W-1]}}, voice_sample[i]};
      end
    end
  end

  // The sum fits in 16 bits only when all bits from the sample MSB upward agree.
  assign l_ovf = (sum_l[SUM_W-1:SAMPLE_W-1] != '0) && (sum_l[SUM_W-1:SAMPLE_W-1] != '1);
  assign r_ovf = (sum_r[SUM_W-1:SAMPLE_W-1] != '0) && (sum_r[SUM_W-1:SAMPLE_W-1] != '1);
  assign l_sat = l_ovf ? (sum_l[SUM_W-1] ? SAT_MIN : SAT_MAX) : sum_l[SAMPLE_W-1:0];
  assign r_sat = r_ovf ? (sum_r[SUM_W-1] ? SAT_MIN : SAT_MAX) : sum_r[SAMPLE_W-1:0];

  always_ff @(posedge clk or negedge pb_in_rst) begin
    if (!pb_in_rst)    shreg <= '0;
    else if (boundary) shreg <= {l_sat, r_sat};
    else if (bck_fall) shreg <= {shreg[30:0], 1'b0};
  end

`ifdef TONE_MIXER_CLIP_FLAG_EN
  always_ff @(posedge clk or negedge pb_in_rst) begin
    if (!pb_in_rst)                       clip_flag <= 1'b0;
    else if (boundary && (l_ovf || r_ovf)) clip_flag <= 1'b1;
  end
`endif

  assign audio_appsel = appsel_q;
  assign audio_sysclk = cnt[1];
  assign audio_bck    = cnt[BCK_LOG2-1];
  assign audio_ws     = cnt[BCK_LOG2+4];
  assign audio_data   = shreg[31];

endmodule
